// File: rtl/wb_pipe_to_litedram_port_pkg.sv
// Shared constants, FSM state type and the lane-select helper for the
// 32-bit pipelined Wishbone to 128-bit LiteDRAM port bridge.
package litedram_port_pkg;

    localparam int LANES = 4;
    localparam int M_DW  = 128;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Move the 4 slave byte selects into the 32-bit lane they address.
    function automatic logic [15:0] lane_sel(input logic [1:0] lane, input logic [3:0] sel);
        return {12'b0, sel} << {lane, 2'b00};
    endfunction

endpackage

// File: rtl/wb_pipe_to_litedram_port.sv
// Bridges one 32-bit pipelined Wishbone slave onto one 128-bit classic
// Wishbone master (LiteDRAM user port), one request outstanding at a time.
module wb_pipe_to_litedram_port
    import litedram_port_pkg::*;
#(
    parameter int S_ADDR_W       = 28,
    parameter int M_ADDR_W       = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [S_ADDR_W-1:0] s_adr,
    input  logic [31:0]         s_dat_w,
    output logic [31:0]         s_dat_r,
    input  logic [3:0]          s_sel,
    input  logic                s_cyc,
    input  logic                s_stb,
    input  logic                s_we,
    output logic                s_stall,
    output logic                s_ack,
    output logic                s_err,
    output logic [M_ADDR_W-1:0] m_adr,
    output logic [M_DW-1:0]     m_dat_w,
    input  logic [M_DW-1:0]     m_dat_r,
    output logic [15:0]         m_sel,
    output logic                m_cyc,
    output logic                m_stb,
    output logic                m_we,
    input  logic                m_ack,
    input  logic                m_err
);

    localparam bit                TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam int                CNT_W    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    state_t                r_state;
    logic [1:0]            r_lane;
    logic [CNT_W-1:0]      r_cnt;
    logic [M_ADDR_W-1:0]   r_m_adr;
    logic [M_DW-1:0]       r_m_dat_w;
    logic [15:0]           r_m_sel;
    logic                  r_m_cyc;
    logic                  r_m_we;
    logic                  r_s_ack;
    logic                  r_s_err;
    logic [31:0]           r_s_dat_r;
    logic                  w_timeout;

    assign w_timeout = TO_EN && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_lane    <= '0;
            r_cnt     <= '0;
            r_m_adr   <= '0;
            r_m_dat_w <= '0;
            r_m_sel   <= '0;
            r_m_cyc   <= 1'b0;
            r_m_we    <= 1'b0;
            r_s_ack   <= 1'b0;
            r_s_err   <= 1'b0;
            r_s_dat_r <= '0;
        end else begin
            r_s_ack   <= 1'b0;
            r_s_err   <= 1'b0;
            r_s_dat_r <= '0;
            case (r_state)
                IDLE: begin
                    if (s_cyc && s_stb) begin
                        r_m_adr   <= s_adr[S_ADDR_W-1:2];
                        r_lane    <= s_adr[1:0];
                        r_m_we    <= s_we;
                        r_m_dat_w <= {LANES{s_dat_w}};
                        r_m_sel   <= lane_sel(s_adr[1:0], s_sel);
                        r_m_cyc   <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= BUSY;
                    end
                end
                BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    // An abort beats any response arriving in the same cycle.
                    if (!s_cyc) begin
                        r_m_cyc <= 1'b0;
                        r_state <= IDLE;
                    end else if (m_err || m_ack || w_timeout) begin
                        r_m_cyc <= 1'b0;
                        r_state <= IDLE;
                        if (m_ack && !m_err) begin
                            r_s_ack   <= 1'b1;
                            r_s_dat_r <= r_m_we ? 32'h0 : m_dat_r[{r_lane, 5'b0} +: 32];
                        end else begin
                            r_s_err <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_stall = (r_state == BUSY);
    // Responses are masked if the slave master has already left the cycle.
    assign s_ack   = r_s_ack & s_cyc;
    assign s_err   = r_s_err & s_cyc;
    assign s_dat_r = r_s_dat_r;
    assign m_adr   = r_m_adr;
    assign m_dat_w = r_m_dat_w;
    assign m_sel   = r_m_sel;
    assign m_cyc   = r_m_cyc;
    assign m_stb   = r_m_cyc;
    assign m_we    = r_m_we;

endmodule

// File: tb/tb_wb_pipe_to_litedram_port.sv
// Directed-vector bench for wb_pipe_to_litedram_port (TIMEOUT_CYCLES=16).
module tb_wb_pipe_to_litedram_port;

    logic          clk = 1'b0;
    logic          rst;
    logic [27:0]   s_adr;
    logic [31:0]   s_dat_w;
    logic [31:0]   s_dat_r;
    logic [3:0]    s_sel;
    logic          s_cyc, s_stb, s_we;
    logic          s_stall, s_ack, s_err;
    logic [23:0]   m_adr;
    logic [127:0]  m_dat_w;
    logic [127:0]  m_dat_r;
    logic [15:0]   m_sel;
    logic          m_cyc, m_stb, m_we;
    logic          m_ack, m_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    wb_pipe_to_litedram_port #(
        .S_ADDR_W(28), .M_ADDR_W(24), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_adr(s_adr), .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_sel(s_sel),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
        .s_stall(s_stall), .s_ack(s_ack), .s_err(s_err),
        .m_adr(m_adr), .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_sel(m_sel),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
        .m_ack(m_ack), .m_err(m_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; s_adr = '0; s_dat_w = '0; s_sel = '0; s_cyc = 1'b0; s_stb = 1'b0;
        s_we = 1'b0; m_dat_r = '0; m_ack = 1'b0; m_err = 1'b0;
        tick(); tick();
        n_checks++; if ({m_cyc, m_stb, m_we, s_stall, s_ack, s_err} !== 6'b0) begin n_errors++;
            $display("FAIL reset_ctrl got %b required 000000", {m_cyc, m_stb, m_we, s_stall, s_ack, s_err}); end
        n_checks++; if (m_adr !== 24'h0 || m_sel !== 16'h0 || m_dat_w !== 128'h0 || s_dat_r !== 32'h0) begin n_errors++;
            $display("FAIL reset_data got adr=%h sel=%h dat_w=%h dat_r=%h required 0", m_adr, m_sel, m_dat_w, s_dat_r); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_write();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 28'h0000006; s_dat_w = 32'hDEADBEEF; s_sel = 4'hF;
        n_checks++; if (s_stall !== 1'b0) begin n_errors++; $display("FAIL wr_idle_stall got %b required 0", s_stall); end
        tick();
        s_stb = 1'b0;
        n_checks++; if (m_adr !== 24'h000001) begin n_errors++; $display("FAIL wr_m_adr got %h required 000001", m_adr); end
        n_checks++; if (m_sel !== 16'h0F00) begin n_errors++; $display("FAIL wr_m_sel got %h required 0f00", m_sel); end
        n_checks++; if (m_dat_w !== {4{32'hDEADBEEF}}) begin n_errors++; $display("FAIL wr_m_dat_w got %h", m_dat_w); end
        n_checks++; if ({m_cyc, m_stb, m_we, s_stall} !== 4'b1111) begin n_errors++;
            $display("FAIL wr_busy_ctrl got %b required 1111", {m_cyc, m_stb, m_we, s_stall}); end
        tick();
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        n_checks++; if (s_ack !== 1'b1 || s_err !== 1'b0) begin n_errors++;
            $display("FAIL wr_ack got ack=%b err=%b required ack=1 err=0", s_ack, s_err); end
        n_checks++; if (m_cyc !== 1'b0 || s_dat_r !== 32'h0) begin n_errors++;
            $display("FAIL wr_done got m_cyc=%b dat_r=%h required 0/0", m_cyc, s_dat_r); end
        tick();
        n_checks++; if (s_ack !== 1'b0) begin n_errors++; $display("FAIL wr_ack_pulse got %b required 0", s_ack); end
        s_cyc = 1'b0;
        tick();
    endtask

    task automatic test_read();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 28'h0000003; s_sel = 4'hF;
        tick();
        s_stb = 1'b0;
        m_dat_r = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        m_ack = 1'b1;
        n_checks++; if (s_ack !== 1'b0 || m_we !== 1'b0) begin n_errors++;
            $display("FAIL rd_early got ack=%b we=%b required 0/0", s_ack, m_we); end
        tick();
        m_ack = 1'b0;
        n_checks++; if (s_ack !== 1'b1 || s_dat_r !== 32'h33333333) begin n_errors++;
            $display("FAIL rd_lane3 got ack=%b dat_r=%h required 1/33333333", s_ack, s_dat_r); end
        tick();
        n_checks++; if (s_ack !== 1'b0) begin n_errors++; $display("FAIL rd_ack_pulse got %b required 0", s_ack); end
        s_cyc = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 28'h0000010; s_sel = 4'hF;
        tick();
        s_adr = 28'h0000015;
        m_dat_r = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        m_ack = 1'b1;
        n_checks++; if (s_stall !== 1'b1 || m_adr !== 24'h000004) begin n_errors++;
            $display("FAIL b2b_first got stall=%b adr=%h required 1/000004", s_stall, m_adr); end
        tick();
        m_ack = 1'b0;
        n_checks++; if (s_ack !== 1'b1 || s_dat_r !== 32'hA0A0A0A0 || s_stall !== 1'b0) begin n_errors++;
            $display("FAIL b2b_ack1 got ack=%b dat_r=%h stall=%b required 1/a0a0a0a0/0", s_ack, s_dat_r, s_stall); end
        tick();
        s_stb = 1'b0;
        m_dat_r = {32'hB3B3B3B3, 32'hB2B2B2B2, 32'hB1B1B1B1, 32'hB0B0B0B0};
        m_ack = 1'b1;
        n_checks++; if (m_cyc !== 1'b1 || m_adr !== 24'h000005 || s_ack !== 1'b0) begin n_errors++;
            $display("FAIL b2b_second got cyc=%b adr=%h ack=%b required 1/000005/0", m_cyc, m_adr, s_ack); end
        tick();
        m_ack = 1'b0;
        n_checks++; if (s_ack !== 1'b1 || s_dat_r !== 32'hB1B1B1B1) begin n_errors++;
            $display("FAIL b2b_ack2 got ack=%b dat_r=%h required 1/b1b1b1b1", s_ack, s_dat_r); end
        tick();
        s_cyc = 1'b0;
        tick();
    endtask

    task automatic test_err_wins();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 28'h0000001;
        tick();
        s_stb = 1'b0; m_ack = 1'b1; m_err = 1'b1;
        tick();
        m_ack = 1'b0; m_err = 1'b0;
        n_checks++; if (s_err !== 1'b1 || s_ack !== 1'b0 || m_cyc !== 1'b0) begin n_errors++;
            $display("FAIL err_wins got err=%b ack=%b cyc=%b required 1/0/0", s_err, s_ack, m_cyc); end
        tick();
        n_checks++; if (s_err !== 1'b0) begin n_errors++; $display("FAIL err_pulse got %b required 0", s_err); end
        s_cyc = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int early_drop = 0;
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 28'h0000020;
        tick();
        s_stb = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (m_cyc !== 1'b1 || s_err !== 1'b0 || s_ack !== 1'b0) early_drop++;
            tick();
        end
        n_checks++; if (early_drop !== 0) begin n_errors++;
            $display("FAIL to_busy got %0d bad BUSY cycles required 0", early_drop); end
        n_checks++; if (m_cyc !== 1'b0 || m_stb !== 1'b0 || s_err !== 1'b1 || s_ack !== 1'b0) begin n_errors++;
            $display("FAIL to_fire got cyc=%b stb=%b err=%b ack=%b required 0/0/1/0", m_cyc, m_stb, s_err, s_ack); end
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        n_checks++; if (s_ack !== 1'b0 || s_err !== 1'b0 || m_cyc !== 1'b0) begin n_errors++;
            $display("FAIL to_late_ack got ack=%b err=%b cyc=%b required 0/0/0", s_ack, s_err, m_cyc); end
        tick();
        n_checks++; if (s_ack !== 1'b0) begin n_errors++; $display("FAIL to_late_ack2 got %b required 0", s_ack); end
        s_cyc = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b0; s_adr = 28'h0000008;
        tick();
        s_stb = 1'b0;
        tick();
        s_cyc = 1'b0; m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        n_checks++; if (m_cyc !== 1'b0 || s_stall !== 1'b0) begin n_errors++;
            $display("FAIL abort_drop got cyc=%b stall=%b required 0/0", m_cyc, s_stall); end
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 28'h0000009; s_dat_w = 32'h12345678; s_sel = 4'h3;
        #1;
        n_checks++; if (s_ack !== 1'b0 || s_err !== 1'b0) begin n_errors++;
            $display("FAIL abort_no_resp got ack=%b err=%b required 0/0", s_ack, s_err); end
        tick();
        s_stb = 1'b0;
        n_checks++; if (m_cyc !== 1'b1 || m_adr !== 24'h000002 || m_sel !== 16'h0030) begin n_errors++;
            $display("FAIL abort_next got cyc=%b adr=%h sel=%h required 1/000002/0030", m_cyc, m_adr, m_sel); end
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        n_checks++; if (s_ack !== 1'b1) begin n_errors++; $display("FAIL abort_next_ack got %b required 1", s_ack); end
        tick();
        s_cyc = 1'b0;
        tick();
    endtask

    task automatic test_reset_busy();
        s_cyc = 1'b1; s_stb = 1'b1; s_we = 1'b1; s_adr = 28'h0000007; s_dat_w = 32'hCAFEF00D; s_sel = 4'h1;
        tick();
        s_stb = 1'b0;
        n_checks++; if (m_cyc !== 1'b1 || m_sel !== 16'h1000) begin n_errors++;
            $display("FAIL rstb_busy got cyc=%b sel=%h required 1/1000", m_cyc, m_sel); end
        rst = 1'b1; m_ack = 1'b1;
        tick();
        rst = 1'b0; m_ack = 1'b0;
        n_checks++; if ({m_cyc, m_stb, m_we, s_stall, s_ack, s_err} !== 6'b0) begin n_errors++;
            $display("FAIL rstb_ctrl got %b required 000000", {m_cyc, m_stb, m_we, s_stall, s_ack, s_err}); end
        n_checks++; if (m_adr !== 24'h0 || m_sel !== 16'h0 || m_dat_w !== 128'h0 || s_dat_r !== 32'h0) begin n_errors++;
            $display("FAIL rstb_data got adr=%h sel=%h dat_w=%h dat_r=%h required 0", m_adr, m_sel, m_dat_w, s_dat_r); end
        tick();
        n_checks++; if (s_ack !== 1'b0 || m_cyc !== 1'b0) begin n_errors++;
            $display("FAIL rstb_after got ack=%b cyc=%b required 0/0", s_ack, m_cyc); end
        s_cyc = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_err_wins();
        test_timeout();
        test_abort();
        test_reset_busy();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
